// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the Hall speed meter.
//   state_t        : measurement FSM encoding (WAIT = not yet timing, RUN = timing edges)
//   HALL_ILLEGAL_* : Hall codes that can never occur on a healthy sensor set
//   next_fwd/rev   : expected next sector for each rotation direction (0 for illegal input)
package motor_ctrl_pkg;

    typedef enum logic {
        WAIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] HALL_ILLEGAL_0 = 3'b000;
    localparam logic [2:0] HALL_ILLEGAL_7 = 3'b111;

    // Forward electrical sequence 1->3->2->6->4->5->1
    function automatic logic [2:0] next_fwd(input logic [2:0] s);
        case (s)
            3'd1:    next_fwd = 3'd3;
            3'd3:    next_fwd = 3'd2;
            3'd2:    next_fwd = 3'd6;
            3'd6:    next_fwd = 3'd4;
            3'd4:    next_fwd = 3'd5;
            3'd5:    next_fwd = 3'd1;
            default: next_fwd = 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] next_rev(input logic [2:0] s);
        case (s)
            3'd1:    next_rev = 3'd5;
            3'd5:    next_rev = 3'd4;
            3'd4:    next_rev = 3'd6;
            3'd6:    next_rev = 3'd2;
            3'd2:    next_rev = 3'd3;
            3'd3:    next_rev = 3'd1;
            default: next_rev = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/hall_debounce.sv
// Hall input conditioning: 2-FF synchronizer followed by a stability filter.
// A synchronized code that differs from the currently accepted code must be seen
// unchanged for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_hall        : raw Hall pins {c,b,a}
//   o_code        : last accepted code (any value, including illegal ones)
//   o_accept      : 1-cycle strobe, o_code just changed
module hall_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [2:0] i_hall,
    output logic [2:0] o_code,
    output logic       o_accept
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [2:0]    r_meta, r_sync, r_acc, r_cand;
    logic [CW-1:0] r_cnt;
    logic          r_stb;
    logic [CW-1:0] w_next_cnt;

    // Any change of the candidate restarts the stability count at 1
    assign w_next_cnt = (r_sync == r_cand) ? r_cnt + 1'b1 : CW'(1);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_meta <= '0;
            r_sync <= '0;
            r_acc  <= '0;
            r_cand <= '0;
            r_cnt  <= '0;
            r_stb  <= 1'b0;
        end else begin
            r_meta <= i_hall;
            r_sync <= r_meta;
            r_stb  <= 1'b0;
            if (r_sync == r_acc) begin
                r_cnt <= '0;
            end else begin
                r_cand <= r_sync;
                if (w_next_cnt == CW'(DEBOUNCE_CYCLES)) begin
                    r_acc <= r_sync;
                    r_stb <= 1'b1;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_next_cnt;
                end
            end
        end
    end

    assign o_code   = r_acc;
    assign o_accept = r_stb;

endmodule

// File: rtl/hall_speed_meter.sv
// BLDC rotor speed measurement from three Hall sensors.
//   clk, rstn     : clock, asynchronous active-low reset
//   hall          : raw Hall inputs {c,b,a}
//   speed_period  : last commutation period in clk cycles (STALL_CYCLES on stall)
//   rev_period    : sum of the last 6 commutation periods
//   new_speed     : 1-cycle strobe, speed_period/rev_period updated
//   sector        : last accepted legal Hall code
//   direction     : 1 = forward, 0 = reverse
//   stall         : set on stall detection, cleared by the next accepted legal edge
//   hall_err      : 1-cycle strobe on illegal code or skipped sector
module hall_speed_meter
    import motor_ctrl_pkg::*;
#(
    parameter int CNT_W           = 32,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STALL_CYCLES    = 100000000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [2:0]       hall,
    output logic [CNT_W-1:0] speed_period,
    output logic [CNT_W+2:0] rev_period,
    output logic             new_speed,
    output logic [2:0]       sector,
    output logic             direction,
    output logic             stall,
    output logic             hall_err
);

    localparam int RW = CNT_W + 3;
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYCLES);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, r_speed;
    logic [CNT_W-1:0] r_hist [0:5];
    logic [RW-1:0]    r_rev, w_rev_nxt;
    logic [2:0]       r_sector;
    logic             r_new, r_dir, r_stall, r_err;

    logic [2:0] w_code;
    logic       w_acc, w_fwd, w_adj, w_flip;
    logic       w_illegal, w_skip, w_arm, w_capture, w_stall_evt;

    hall_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .i_clk    (clk),
        .i_rstn   (rstn),
        .i_hall   (hall),
        .o_code   (w_code),
        .o_accept (w_acc)
    );

    assign w_fwd  = (w_code == next_fwd(r_sector));
    assign w_adj  = w_fwd || (w_code == next_rev(r_sector));
    assign w_flip = (w_fwd != r_dir);
    // A direction change restarts the revolution sum from the new period alone
    assign w_rev_nxt = w_flip ? RW'(r_cnt)
                              : r_rev + RW'(r_cnt) - RW'(r_hist[5]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= WAIT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_illegal   = 1'b0;
        w_skip      = 1'b0;
        w_arm       = 1'b0;
        w_capture   = 1'b0;
        w_stall_evt = 1'b0;
        if (w_acc) begin
            if (w_code == HALL_ILLEGAL_0 || w_code == HALL_ILLEGAL_7) begin
                w_illegal = 1'b1;
            // Returning to the current sector (e.g. after an illegal code) is not an edge
            end else if (w_code != r_sector) begin
                if (r_sector != 3'd0 && !w_adj) begin
                    w_skip      = 1'b1;
                    w_state_nxt = WAIT;
                end else if (r_state == WAIT) begin
                    w_arm       = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_capture = 1'b1;
                end
            end
        end
        // A legal edge in the same cycle takes priority over the stall
        if (r_state == RUN && r_cnt == STALL_MAX && !w_capture && !w_skip) begin
            w_stall_evt = 1'b1;
            w_state_nxt = WAIT;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt    <= '0;
            r_speed  <= '0;
            r_rev    <= '0;
            r_sector <= '0;
            r_new    <= 1'b0;
            r_dir    <= 1'b0;
            r_stall  <= 1'b0;
            r_err    <= 1'b0;
            for (int i = 0; i < 6; i++) r_hist[i] <= '0;
        end else begin
            r_new <= 1'b0;
            r_err <= w_illegal | w_skip;
            if (r_cnt != STALL_MAX) r_cnt <= r_cnt + 1'b1;

            if (w_skip) begin
                r_sector <= w_code;
                r_stall  <= 1'b0;
            end
            if (w_arm) begin
                r_sector <= w_code;
                r_cnt    <= CNT_W'(1);
                r_stall  <= 1'b0;
            end
            if (w_capture) begin
                r_sector <= w_code;
                r_speed  <= r_cnt;
                r_dir    <= w_fwd;
                r_cnt    <= CNT_W'(1);
                r_new    <= 1'b1;
                r_stall  <= 1'b0;
                r_rev    <= w_rev_nxt;
                r_hist[0] <= r_cnt;
                for (int i = 1; i < 6; i++) r_hist[i] <= w_flip ? '0 : r_hist[i-1];
            end
            if (w_stall_evt) begin
                r_stall <= 1'b1;
                r_speed <= STALL_MAX;
                r_new   <= 1'b1;
                r_rev   <= '0;
                for (int i = 0; i < 6; i++) r_hist[i] <= '0;
            end
        end
    end

    assign speed_period = r_speed;
    assign rev_period   = r_rev;
    assign new_speed    = r_new;
    assign sector       = r_sector;
    assign direction    = r_dir;
    assign stall        = r_stall;
    assign hall_err     = r_err;

endmodule
